mo_linebuf_ctrl: RTL and testbench
==================================

Name: mo_linebuf_ctrl

Overview:
Sequencer for the ping-pong motion-object line buffer (two 256x4 RAMs: 3-bit colour plus priority bit). It selects which bank renders and which displays, and toggles them every scanline. On the render bank it walks an 8-pixel object write burst from a start X. On the display bank it generates the read address from the horizontal count and a clear-behind-read strobe. It sits between the motion-object fetch logic and the line buffer RAMs.

Parameters:
OBJ_W, 8, pixels written per object burst
XW, 8, address width of each line buffer (256 entries)
CLR_VAL, 4'hF, value written behind the read pointer (transparent)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
ce5  in  1  pixel-rate clock enable; all state advances only when ce5=1
line_start  in  1  scanline boundary strobe, qualified by ce5
hcount  in  XW  display horizontal position
obj_start  in  1  request to draw one object, qualified by ce5
obj_x  in  XW  first pixel X of object
pix_opaque  in  1  current burst pixel is non-transparent
bank  out  1  0: bank A renders / bank B displays; 1: the reverse
addr_a  out  XW  bank A address
addr_b  out  XW  bank B address
we_a  out  1  bank A write strobe
we_b  out  1  bank B write strobe
clr_sel  out  1  1 = the display bank's data mux selects CLR_VAL
busy  out  1  burst in progress
obj_done  out  1  one-ce5 pulse on burst completion
obj_abort  out  1  one-ce5 pulse when line_start truncates a burst

Behaviour:
- Reset (reset_n=0 at clk edge) sets every output to 0:
  - bank=0, busy=0, obj_done=0, obj_abort=0, we_a=0, we_b=0, clr_sel=0, addr_a=addr_b=0.
  - Write FSM returns to IDLE; pixel counter resets to 0.
  - Reset mid-burst abandons the burst silently; obj_abort stays 0.
- Bank swap: on ce5 with line_start=1, bank toggles. The new mapping takes effect on the following ce5 cycle.
- Write FSM states: IDLE, DRAW.
  - IDLE to DRAW: on ce5 with obj_start=1 and line_start=0. Latch wptr=obj_x, cnt=0, set busy=1.
  - obj_start while busy=1 is ignored. The requester must wait for busy=0.
  - In DRAW, each ce5 issues one write cycle at wptr.
    - Write strobe of the render bank = pix_opaque. Transparent pixels are not written.
    - Then wptr increments mod 2^XW (255 wraps to 0) and cnt increments.
  - DRAW to IDLE after write number OBJ_W (cnt=OBJ_W-1): obj_done=1 for that ce5 cycle, busy=0 on the next.
  - line_start during DRAW: the write for that cycle is suppressed. The FSM goes to IDLE with obj_abort=1 for one ce5 cycle and obj_done=0.
  - obj_start together with line_start is dropped.
- Display side:
  - The display bank's address is hcount, registered once. Read data is valid 1 ce5 cycle after the hcount presentation.
  - The display bank's write strobe is ce5 every cycle, with clr_sel=1. This writes CLR_VAL to the location just read, so the bank is transparent for its next render line.
  - During the line_start cycle both banks' strobes are 0. This prevents a write landing in the wrong bank.
- addr_a/addr_b mux:
  - The render bank gets wptr; the display bank gets the registered hcount.
  - When idle, the render bank's address holds its last value and its write strobe is 0.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package mo_pkg holds:
  - constants MO_OBJ_W=8, MO_XW=8, MO_CLR=4'hF;
  - enum mo_wstate_t {IDLE, DRAW}.
- One natural sub-module, mo_burst_gen: write FSM, wptr, cnt, done/abort pulses.
- The top level keeps the bank toggle, address/strobe muxing and the clear logic.

Test Plan:
- Reset and swap: reset_n low 2 cycles, then line_start pulse. Required: all outputs 0 during reset; bank=1 after the strobe; we_a=we_b=0 in the line_start cycle.
- Basic burst: bank=0, obj_x=0x10, pix_opaque=1 for 8 ce5 cycles. Required: addr_a = 0x10..0x17 with we_a each cycle; obj_done on the 8th cycle; busy back to 0.
- Wrap and transparency: obj_x=0xFC, pix_opaque pattern 1,0,1,1,0,0,1,1. Required: addr_a = FC,FD,FE,FF,00,01,02,03; we_a only at FC,FE,FF,02,03.
- Abort: line_start on the 4th burst pixel. Required: 3 writes only, obj_abort=1, obj_done=0, bank toggled, busy=0.
- Busy and clear: obj_start again while busy=1 is ignored (single burst, 8 writes). Concurrently with bank=0, hcount 0x00..0x05 gives addr_b = hcount delayed 1 cycle, we_b=1 and clr_sel=1 every ce5.
- ce5 gating: hold ce5=0 for 5 cycles mid-burst. Required: wptr, cnt, bank and strobes frozen; the burst resumes with no lost or duplicated address.

Source files
------------

// File: rtl/mo_linebuf_ctrl_pkg.sv
// Shared constants and types for the motion-object line buffer sequencer.
package mo_pkg;

    localparam int          MO_OBJ_W = 8;
    localparam int          MO_XW    = 8;
    localparam logic [3:0]  MO_CLR   = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } mo_wstate_t;

endpackage

// File: rtl/mo_burst_gen.sv
// Object write burst walker: latches a start X and steps OBJ_W pixel writes,
// flagging completion or truncation by a scanline boundary.
module mo_burst_gen
    import mo_pkg::*;
#(
    parameter int OBJ_W = MO_OBJ_W,
    parameter int XW    = MO_XW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce5,
    input  logic          line_start,
    input  logic          obj_start,
    input  logic [XW-1:0] obj_x,
    output logic          wr_en,
    output logic [XW-1:0] wptr,
    output logic          busy,
    output logic          obj_done,
    output logic          obj_abort
);

    localparam int CW = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;

    mo_wstate_t    state_q, state_d;
    logic [XW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        abort_d = abort_q;
        wr_en   = 1'b0;
        if (ce5) begin
            done_d  = 1'b0;
            abort_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // busy lingers through the done cycle, so a request there is dropped
                    busy_d = 1'b0;
                    if (obj_start && !line_start && !busy_q) begin
                        state_d = DRAW;
                        wptr_d  = obj_x;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                DRAW: begin
                    if (line_start) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CW'(OBJ_W - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign wptr      = wptr_q;
    assign busy      = busy_q;
    assign obj_done  = done_q;
    assign obj_abort = abort_q;

endmodule

// File: rtl/mo_linebuf_ctrl.sv
// Ping-pong line buffer sequencer: bank toggle, render/display address and
// strobe muxing, and clear-behind-read on the display bank.
module mo_linebuf_ctrl
    import mo_pkg::*;
#(
    parameter int OBJ_W = MO_OBJ_W,
    parameter int XW    = MO_XW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce5,
    input  logic          line_start,
    input  logic [XW-1:0] hcount,
    input  logic          obj_start,
    input  logic [XW-1:0] obj_x,
    input  logic          pix_opaque,
    output logic          bank,
    output logic [XW-1:0] addr_a,
    output logic [XW-1:0] addr_b,
    output logic          we_a,
    output logic          we_b,
    output logic          clr_sel,
    output logic          busy,
    output logic          obj_done,
    output logic          obj_abort
);

    logic          wr_en;
    logic [XW-1:0] wptr;

    mo_burst_gen #(
        .OBJ_W (OBJ_W),
        .XW    (XW)
    ) u_burst (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce5        (ce5),
        .line_start (line_start),
        .obj_start  (obj_start),
        .obj_x      (obj_x),
        .wr_en      (wr_en),
        .wptr       (wptr),
        .busy       (busy),
        .obj_done   (obj_done),
        .obj_abort  (obj_abort)
    );

    logic          bank_q, bank_d;
    logic [XW-1:0] addr_a_q, addr_a_d;
    logic [XW-1:0] addr_b_q, addr_b_d;
    logic          we_a_q, we_a_d;
    logic          we_b_q, we_b_d;
    logic          clr_q, clr_d;
    logic [XW-1:0] r_addr;
    logic          r_we;
    logic          d_we;

    always_comb begin
        bank_d   = bank_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        we_a_d   = we_a_q;
        we_b_d   = we_b_q;
        clr_d    = clr_q;
        // Render side uses the bank mapping in force before any toggle this cycle
        r_addr   = wr_en ? wptr : (bank_q ? addr_b_q : addr_a_q);
        r_we     = wr_en & pix_opaque;
        d_we     = ~line_start;
        if (ce5) begin
            bank_d = bank_q ^ line_start;
            clr_d  = ~line_start;
            if (!bank_q) begin
                addr_a_d = r_addr;
                we_a_d   = r_we;
                addr_b_d = hcount;
                we_b_d   = d_we;
            end else begin
                addr_b_d = r_addr;
                we_b_d   = r_we;
                addr_a_d = hcount;
                we_a_d   = d_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            clr_q    <= clr_d;
        end
    end

    assign bank    = bank_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign we_a    = we_a_q;
    assign we_b    = we_b_q;
    assign clr_sel = clr_q;

endmodule

// File: tb/tb_mo_linebuf_ctrl.sv
// Scoreboard bench for mo_linebuf_ctrl: bursts with bank 0 rendering into A.
module tb_mo_linebuf_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, ce5, line_start, obj_start, pix_opaque;
    logic [7:0] hcount, obj_x;
    logic       bank, we_a, we_b, clr_sel, busy, obj_done, obj_abort;
    logic [7:0] addr_a, addr_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] hc;
        logic       done;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mo_linebuf_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce5        (ce5),
        .line_start (line_start),
        .hcount     (hcount),
        .obj_start  (obj_start),
        .obj_x      (obj_x),
        .pix_opaque (pix_opaque),
        .bank       (bank),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .we_a       (we_a),
        .we_b       (we_b),
        .clr_sel    (clr_sel),
        .busy       (busy),
        .obj_done   (obj_done),
        .obj_abort  (obj_abort)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One object burst into bank A (bank must be 0); optional abort / ce5 gap
    task automatic do_burst(input logic [7:0] x, input logic [7:0] pat, input int abort_at,
                            input bit hold_start, input int gate_at);
        exp_t       e;
        logic [7:0] last_addr;
        logic       last_we;
        obj_start = 1'b1;
        obj_x     = x;
        line_start = 1'b0;
        ce5       = 1'b1;
        tick();
        chk("start_busy", busy, 1);
        chk("start_we_a", we_a, 0);
        obj_start = hold_start;
        last_addr = addr_a;
        last_we   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gate_at) begin
                ce5 = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    pix_opaque = ~pix_opaque;
                    hcount     = 8'hEE;
                    tick();
                    chk("gate_addr_a", addr_a, last_addr);
                    chk("gate_we_a", we_a, last_we);
                    chk("gate_busy", busy, 1);
                    chk("gate_bank", bank, 0);
                end
                ce5 = 1'b1;
            end
            pix_opaque = pat[i];
            hcount     = 8'(i);
            if (i == abort_at) begin
                line_start = 1'b1;
                tick();
                line_start = 1'b0;
                chk("abort_pulse", obj_abort, 1);
                chk("abort_done", obj_done, 0);
                chk("abort_busy", busy, 0);
                chk("abort_bank", bank, 1);
                chk("abort_we_a", we_a, 0);
                chk("abort_we_b", we_b, 0);
                tick();
                chk("post_abort_we_b", we_b, 0);
                chk("post_abort_pulse", obj_abort, 0);
                chk("post_abort_busy", busy, 0);
                return;
            end
            e.addr = x + 8'(i);
            e.we   = pat[i];
            e.hc   = 8'(i);
            e.done = (i == 7);
            sb.push_back(e);
            tick();
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("wr_addr_a", addr_a, e.addr);
                chk("wr_we_a", we_a, e.we);
                chk("clr_addr_b", addr_b, e.hc);
                chk("clr_we_b", we_b, 1);
                chk("clr_sel", clr_sel, 1);
                chk("done", obj_done, e.done);
                chk("busy", busy, 1);
                chk("abort_idle", obj_abort, 0);
                last_addr = e.addr;
                last_we   = e.we;
            end
        end
        obj_start = 1'b0;
        tick();
        chk("end_busy", busy, 0);
        chk("end_done", obj_done, 0);
        chk("end_we_a", we_a, 0);
        chk("end_addr_hold", addr_a, last_addr);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_we_a", we_a, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        ce5        = 1'b1;
        line_start = 1'b1;
        obj_start  = 1'b1;
        obj_x      = 8'h33;
        hcount     = 8'h55;
        pix_opaque = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_bank", bank, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", obj_done, 0);
            chk("rst_abort", obj_abort, 0);
            chk("rst_we", {we_a, we_b}, 0);
            chk("rst_clr", clr_sel, 0);
            chk("rst_addr", {addr_a, addr_b}, 0);
        end
        reset_n    = 1'b1;
        line_start = 1'b0;
        obj_start  = 1'b0;
        tick();
        chk("idle_bank", bank, 0);
        chk("idle_we_a0", we_a, 0);
        chk("idle_we_b0", we_b, 1);
        chk("idle_addr_b", addr_b, 8'h55);

        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("swap_bank", bank, 1);
        chk("swap_we_a", we_a, 0);
        chk("swap_we_b", we_b, 0);
        tick();
        chk("swapped_we_a", we_a, 1);
        chk("swapped_we_b", we_b, 0);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("swap_back", bank, 0);

        do_burst(8'h10, 8'hFF, -1, 1'b0, -1);
        do_burst(8'hFC, 8'hCD, -1, 1'b0, -1);
        do_burst(8'h40, 8'hFF, -1, 1'b1, -1);
        do_burst(8'h80, 8'hA5, -1, 1'b0, 3);
        do_burst(8'h20, 8'hFF, 3, 1'b0, -1);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
